dsp_mac_engine: RTL



---
 rtl/dsp_mac_pkg.sv | 50 +++++
 rtl/dsp_pipe_reg.sv | 36 +++
 rtl/dsp_mac_engine.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_pkg.sv
// -----------------------------------------------------------------------------
// dsp_mac_pkg
// Shared types and helpers for the dsp_mac_engine slice:
//   - add/sub and accumulate-mode encodings
//   - control bundles that travel down the pipeline with each sample
//   - saturation bound helpers for an arbitrary signed width
// -----------------------------------------------------------------------------
package dsp_mac_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_e;

  typedef enum logic {
    ACC_SINGLE = 1'b0,
    ACC_WINDOW = 1'b1
  } acc_mode_e;

  // Control bits captured in S1 together with the operands.
  typedef struct packed {
    logic      valid;
    logic      pre_en;
    addsub_e   pre_sub;
    acc_mode_e acc_mode;
    addsub_e   post_sub;
  } ctrl_t;

  // After the pre-adder only the post-add controls are still needed.
  typedef struct packed {
    logic      valid;
    acc_mode_e acc_mode;
    addsub_e   post_sub;
  } post_ctrl_t;

  localparam int CTRL_W  = $bits(ctrl_t);
  localparam int POST_W  = $bits(post_ctrl_t);
  localparam int BOUND_W = 128;

  // Largest positive value of a w-bit signed number, in the low w bits.
  function automatic logic [BOUND_W-1:0] sat_max(input int unsigned w);
    return (BOUND_W'(1) << (w - 1)) - BOUND_W'(1);
  endfunction

  // Bit pattern of the most negative w-bit signed number, in the low w bits.
  function automatic logic [BOUND_W-1:0] sat_min(input int unsigned w);
    return BOUND_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// -----------------------------------------------------------------------------
// dsp_pipe_reg
// Generic pipeline register: async active-low reset, synchronous clear that
// overrides the enable, and a clock enable that holds the value when low.
// Ports:
//   clk, rst_n : clock / async active-low reset
//   ce         : load enable
//   clr        : synchronous clear (priority over ce)
//   d / q      : WIDTH-bit data in / registered data out
// -----------------------------------------------------------------------------
module dsp_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: non-blocking assignment so every stage samples the pre-edge value of
  // the stage before it; blocking here would collapse the pipeline.
  // NOTE: the datapath bits are reset along with the valid tags so outputs such
  // as M read a defined 0 after reset instead of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ce) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dsp_mac_engine.sv
// -----------------------------------------------------------------------------
// dsp_mac_engine
// Valid-tagged pre-add / multiply / post-add-accumulate slice.
//   S1 operands + controls, S2 pre-adder, S3 product M, S4 post-adder/acc -> P.
// Ports:
//   clk, rst_n         : clock / async active-low reset
//   ce                 : global enable, 0 freezes all state
//   flush              : synchronous clear of pipeline and window (beats ce)
//   in_valid           : sample qualifier
//   a, b, d, c         : signed operands (c is the P_WIDTH bias/addend)
//   pre_en, pre_sub    : pre-adder select / D+B vs D-B
//   acc_mode, post_sub : single-shot vs windowed / C+M vs C-M (single-shot)
//   acc_len            : products per window, 0 acts as 1
//   p, m               : result (held between out_valids) / stage-3 product
//   out_valid, ovf     : new result strobe / overflow seen for that result
//   busy               : window open or any stage holds a valid sample
// -----------------------------------------------------------------------------
module dsp_mac_engine
  import dsp_mac_pkg::*;
#(
  parameter int A_WIDTH  = 18,
  parameter int B_WIDTH  = 18,
  parameter int P_WIDTH  = 48,
  parameter int LEN_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ce,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  logic [B_WIDTH-1:0]         d,
  input  logic [P_WIDTH-1:0]         c,
  input  logic                       pre_en,
  input  logic                       pre_sub,
  input  logic                       acc_mode,
  input  logic                       post_sub,
  input  logic [LEN_W-1:0]           acc_len,
  output logic [P_WIDTH-1:0]         p,
  output logic [A_WIDTH+B_WIDTH:0]   m,
  output logic                       out_valid,
  output logic                       ovf,
  output logic                       busy
);

  localparam int M_W  = A_WIDTH + B_WIDTH + 1;
  localparam int X_W  = B_WIDTH + 1;
  localparam int S_W  = P_WIDTH + 1;
  localparam int S1_W = A_WIDTH + 2 * B_WIDTH + P_WIDTH + LEN_W + CTRL_W;
  localparam int S2_W = A_WIDTH + P_WIDTH + LEN_W + POST_W + X_W;
  localparam int S3_W = P_WIDTH + LEN_W + POST_W + M_W;

  localparam logic [P_WIDTH-1:0] P_MAX = P_WIDTH'(sat_max(P_WIDTH));
  localparam logic [P_WIDTH-1:0] P_MIN = P_WIDTH'(sat_min(P_WIDTH));

  if (P_WIDTH < A_WIDTH + B_WIDTH + 1) begin : g_width_check
    $error("dsp_mac_engine: P_WIDTH must be >= A_WIDTH+B_WIDTH+1");
  end

  // ---------------------------------------------------------------- S1
  ctrl_t                      ctrl_in, s1_ctrl;
  logic [S1_W-1:0]            s1_q;
  logic signed [A_WIDTH-1:0]  s1_a;
  logic signed [B_WIDTH-1:0]  s1_b, s1_d;
  logic signed [P_WIDTH-1:0]  s1_c;
  logic [LEN_W-1:0]           s1_len;

  assign ctrl_in = '{valid:    in_valid,
                     pre_en:   pre_en,
                     pre_sub:  addsub_e'(pre_sub),
                     acc_mode: acc_mode_e'(acc_mode),
                     post_sub: addsub_e'(post_sub)};

  dsp_pipe_reg #(.WIDTH(S1_W)) u_s1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(flush),
    .d({a, b, d, c, acc_len, ctrl_in}),
    .q(s1_q)
  );
  assign {s1_a, s1_b, s1_d, s1_c, s1_len, s1_ctrl} = s1_q;

  // ---------------------------------------------------------------- S2
  // One extra bit makes D+B and D-B exact for any operands.
  logic signed [X_W-1:0] b_x, d_x, pre;
  assign b_x = {s1_b[B_WIDTH-1], s1_b};
  assign d_x = {s1_d[B_WIDTH-1], s1_d};

  // NOTE: pre gets a value on every path through the block, so no latch.
  always_comb begin
    pre = b_x;
    if (s1_ctrl.pre_en) begin
      pre = (s1_ctrl.pre_sub == OP_SUB) ? (d_x - b_x) : (d_x + b_x);
    end
  end

  post_ctrl_t                 s1_post, s2_ctrl;
  logic [S2_W-1:0]            s2_q;
  logic signed [A_WIDTH-1:0]  s2_a;
  logic signed [P_WIDTH-1:0]  s2_c;
  logic [LEN_W-1:0]           s2_len;
  logic signed [X_W-1:0]      s2_pre;

  assign s1_post = '{valid: s1_ctrl.valid, acc_mode: s1_ctrl.acc_mode,
                     post_sub: s1_ctrl.post_sub};

  dsp_pipe_reg #(.WIDTH(S2_W)) u_s2 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(flush),
    .d({s1_a, s1_c, s1_len, s1_post, pre}),
    .q(s2_q)
  );
  assign {s2_a, s2_c, s2_len, s2_ctrl, s2_pre} = s2_q;

  // ---------------------------------------------------------------- S3
  // Both factors extended to the full product width; the low M_W bits of the
  // M_W x M_W product are the exact signed product.
  logic signed [M_W-1:0] a_x, pre_x, prod;
  assign a_x   = {{(M_W - A_WIDTH){s2_a[A_WIDTH-1]}}, s2_a};
  assign pre_x = {{(M_W - X_W){s2_pre[X_W-1]}}, s2_pre};
  assign prod  = a_x * pre_x;

  post_ctrl_t                 s3_ctrl;
  logic [S3_W-1:0]            s3_q;
  logic signed [P_WIDTH-1:0]  s3_c;
  logic [LEN_W-1:0]           s3_len;
  logic signed [M_W-1:0]      s3_m;

  dsp_pipe_reg #(.WIDTH(S3_W)) u_s3 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(flush),
    .d({s2_c, s2_len, s2_ctrl, prod}),
    .q(s3_q)
  );
  assign {s3_c, s3_len, s3_ctrl, s3_m} = s3_q;

  // ---------------------------------------------------------------- S4
  logic [LEN_W-1:0]          cnt, len_lat, len_new, win_len;
  logic [LEN_W:0]            cnt_inc;
  logic                      win_open, last;
  logic signed [P_WIDTH-1:0] acc, p_q, res;
  logic signed [S_W-1:0]     m_x, base, sum;
  logic                      evt, ov_q, ovf_q, win_ovf;

  always_comb begin
    len_new  = (s3_len == '0) ? LEN_W'(1) : s3_len;
    win_open = (cnt != '0);
    // The first sample of a window supplies the length; later ones are ignored.
    win_len  = win_open ? len_lat : len_new;
    cnt_inc  = {1'b0, cnt} + {{LEN_W{1'b0}}, 1'b1};
    last     = (cnt_inc == {1'b0, win_len});

    m_x  = {{(S_W - M_W){s3_m[M_W-1]}}, s3_m};
    base = {s3_c[P_WIDTH-1], s3_c};
    // Single-shot samples always start from C, so they never touch acc.
    if (s3_ctrl.acc_mode == ACC_WINDOW && win_open) begin
      base = {acc[P_WIDTH-1], acc};
    end
    if (s3_ctrl.acc_mode == ACC_SINGLE && s3_ctrl.post_sub == OP_SUB) begin
      sum = base - m_x;
    end else begin
      sum = base + m_x;
    end

    evt = sum[S_W-1] ^ sum[S_W-2];
    res = sum[P_WIDTH-1:0];
    if (evt && (SATURATE != 0)) begin
      res = sum[S_W-1] ? P_MIN : P_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      len_lat <= '0;
      ov_q    <= 1'b0;
      ovf_q   <= 1'b0;
      win_ovf <= 1'b0;
    end else if (flush) begin
      p_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      len_lat <= '0;
      ov_q    <= 1'b0;
      ovf_q   <= 1'b0;
      win_ovf <= 1'b0;
    end else if (ce) begin
      ov_q <= 1'b0;
      if (s3_ctrl.valid) begin
        if (s3_ctrl.acc_mode == ACC_SINGLE) begin
          p_q   <= res;
          ovf_q <= evt;
          ov_q  <= 1'b1;
        end else if (last) begin
          p_q     <= res;
          ovf_q   <= win_ovf | evt;
          ov_q    <= 1'b1;
          cnt     <= '0;
          win_ovf <= 1'b0;
        end else begin
          acc     <= res;
          cnt     <= cnt_inc[LEN_W-1:0];
          win_ovf <= win_ovf | evt;
          if (!win_open) begin
            len_lat <= len_new;
          end
        end
      end
    end
  end

  // A result loaded into S4 stays pending while ce is low and is shown only
  // once ce is high again, so it is never reported twice.
  assign out_valid = ov_q & ce;
  assign p         = p_q;
  assign m         = s3_m;
  assign ovf       = ovf_q;
  assign busy      = win_open | s1_ctrl.valid | s2_ctrl.valid | s3_ctrl.valid;

endmodule
